dmem_mmio_responder: RTL

// - Responder end of the processor's dmem port: serves address/data/wren, returns q_dmem in the same cycle.
// - Backs a word-addressed data RAM plus a small MMIO window: byte TX FIFO (ready/valid drain), status/control register, free-running timer.
// - Sits in the wrapper between the processor's dmem pins and an external byte sink (UART TX or bench monitor).

---
 rtl/dmem_mmio_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: processor dmem responder with a word RAM and an MMIO
// window. The window holds a byte TX FIFO, a status/control register and a
// free-running timer. Reads are combinational so the processor captures
// q_dmem at the next edge.
module dmem_mmio_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000F000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RAM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [32:0]      RAM_LIMIT   = 33'(RAM_WORDS);
    localparam logic [31:0]      TXDATA_ADDR = MMIO_BASE;
    localparam logic [31:0]      STATUS_ADDR = MMIO_BASE + 32'd1;
    localparam logic [31:0]      TIMER_ADDR  = MMIO_BASE + 32'd2;
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [31:0]      timer;

    logic is_ram;
    logic is_txdata;
    logic is_status;
    logic is_timer;
    logic empty;
    logic full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic overflow_evt;
    logic clear_req;

    // Address decode and FIFO handshake qualifiers.
    always_comb begin
        is_ram       = {1'b0, address_dmem} < RAM_LIMIT;
        is_txdata    = address_dmem == TXDATA_ADDR;
        is_status    = address_dmem == STATUS_ADDR;
        is_timer     = address_dmem == TIMER_ADDR;
        empty        = count == '0;
        full         = count == FULL_COUNT;
        pop          = !reset && !empty && tx_ready;
        push_req     = !reset && wren && is_txdata;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok      = push_req && (!full || pop);
        overflow_evt = push_req && full && !pop;
        clear_req    = !reset && wren && is_status && data[10];
    end

    // Data RAM: contents survive reset, writes blocked while reset is high.
    always_ff @(posedge clock) begin
        if (!reset && wren && is_ram) begin
            ram[address_dmem[ADDR_WIDTH-1:0]] <= data;
        end
    end

    // FIFO storage; stale entries are masked by the count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data[7:0];
        end
    end

    // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    // Sticky overflow flag; a fresh overflow beats a same-edge clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflow_evt) begin
            overflow <= 1'b1;
        end else if (clear_req) begin
            overflow <= 1'b0;
        end
    end

    // Free-running timer; a software load takes priority over the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (wren && is_timer) begin
            timer <= data;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // Read mux and TX head; unmapped and TXDATA reads return zero.
    always_comb begin
        q_dmem   = '0;
        tx_valid = !empty;
        tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
        if (is_ram) begin
            q_dmem = ram[address_dmem[ADDR_WIDTH-1:0]];
        end else if (is_status) begin
            q_dmem = {21'd0, overflow, full, empty, 8'(count)};
        end else if (is_timer) begin
            q_dmem = timer;
        end
    end

endmodule
